// File: rtl/cdc_4phase_tx.sv
// Source end of a 4-phase req/ack clock-domain crossing with a synchronized ack.
// Optional sticky ack timeout: define CDC_4PHASE_TX_TIMEOUT_EN.
module cdc_4phase_tx #(
  parameter int DataWidth     = 32,
  parameter int STAGES        = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 async_req_o,
  input  logic                 async_ack_i,
  output logic [DataWidth-1:0] async_data_o,
  output logic                 timeout_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ_HI = 2'd1;
  localparam logic [1:0] REQ_LO = 2'd2;

  if (STAGES < 2 || TimeoutCycles < 1) begin : g_bad_param
    $error("cdc_4phase_tx: STAGES must be >= 2 and TimeoutCycles >= 1");
  end

  logic [1:0]        state, state_nxt;
  logic [STAGES-1:0] ack_pipe;
  logic              ack_s;

  // Only the last flop of the chain is allowed to steer the FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ack_pipe <= '0;
    else         ack_pipe <= {ack_pipe[STAGES-2:0], async_ack_i};
  end
  assign ack_s = ack_pipe[STAGES-1];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = REQ_HI;
      REQ_HI:  if (ack_s)   state_nxt = REQ_LO;
      REQ_LO:  if (!ack_s)  state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Data is loaded only on the accept edge, so it is frozen for the whole handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      async_req_o  <= 1'b0;
      async_data_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && valid_i) begin
        async_req_o  <= 1'b1;
        async_data_o <= data_i;
      end else if (state == REQ_HI && ack_s) begin
        async_req_o  <= 1'b0;
      end
    end
  end

  assign ready_o = (state == IDLE);

`ifdef CDC_4PHASE_TX_TIMEOUT_EN
  localparam int               CntW   = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0]  TO_MAX = CntW'(TimeoutCycles);
  localparam logic [CntW-1:0]  TO_PRE = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] to_cnt;
  logic            to_flag;

  // Counts cycles spent in one busy state; flag is sticky, FSM never aborts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (state_nxt != state) begin
      to_cnt  <= '0;
    end else if (state != IDLE && to_cnt != TO_MAX) begin
      to_cnt  <= to_cnt + CntW'(1);
      if (to_cnt == TO_PRE) to_flag <= 1'b1;
    end
  end
  assign timeout_o = to_flag;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_4phase_tx.sv
// Randomized + directed bench for cdc_4phase_tx using an event-time reference model.
module tb_cdc_4phase_tx;
  localparam int DW = 32;
  localparam int S  = 2;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] data_i = '0;
  logic          async_req_o;
  logic          async_ack_i = 1'b0;
  logic [DW-1:0] async_data_o;
  logic          timeout_o;

  cdc_4phase_tx #(.DataWidth(DW), .STAGES(S), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .async_req_o(async_req_o), .async_ack_i(async_ack_i),
    .async_data_o(async_data_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference model: expected outputs plus scheduled event times.
  bit            m_ready = 1'b1;
  bit            m_req = 1'b0;
  bit            m_to = 1'b0;
  logic [DW-1:0] m_data = '0;
  int            fall_at = -1;
  int            rdy_at = -1;
  logic [DW-1:0] sent_q[$];
  int            acc_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "/ready"}, 64'(ready_o), 64'(m_ready));
    chk({tag, "/req"}, 64'(async_req_o), 64'(m_req));
    chk({tag, "/data"}, 64'(async_data_o), 64'(m_data));
    chk({tag, "/timeout"}, 64'(timeout_o), 64'(m_to));
  endtask

  // One clock: the model accepts where the spec says IDLE samples valid_i.
  task automatic tick();
    if (m_ready && valid_i) begin
      m_ready = 1'b0;
      m_req   = 1'b1;
      m_data  = data_i;
      sent_q.push_back(data_i);
      acc_cyc.push_back(cyc + 1);
    end
    @(posedge clk_i);
    #1;
    cyc++;
    if (cyc == fall_at) m_req = 1'b0;
    if (cyc == rdy_at)  m_ready = 1'b1;
  endtask

  // Ack edges: req drops / ready returns S+1 cycles after the remote edge.
  task automatic set_ack(input bit v);
    if (v && !async_ack_i) fall_at = cyc + S + 1;
    if (!v && async_ack_i) rdy_at = cyc + S + 1;
    async_ack_i = v;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    async_ack_i = 1'b0;
    valid_i = 1'b0;
    #1;
    m_ready = 1'b1; m_req = 1'b0; m_to = 1'b0; m_data = '0;
    fall_at = -1; rdy_at = -1;
    sent_q.delete(); acc_cyc.delete();
    chk_all("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic handshake(input int d, input string tag);
    int n;
    for (int i = 0; i < d; i++) begin tick(); chk_all(tag); end
    set_ack(1'b1);
    n = 0;
    while (async_req_o && n < 40) begin tick(); n++; chk_all(tag); end
    chk({tag, "/req_fall_lat"}, 64'(n), 64'(S + 1));
    set_ack(1'b0);
    n = 0;
    while (!ready_o && n < 40) begin tick(); n++; chk_all(tag); end
    chk({tag, "/ready_lat"}, 64'(n), 64'(S + 1));
  endtask

  initial begin
    logic [DW-1:0] words[3];
    int widx, ndeliv, nacc, rwait, a;

    // Reset release with valid_i low: idle outputs hold.
    do_reset();
    for (int i = 0; i < 10; i++) begin tick(); chk_all("idle"); end

    // Single word with a slow manual remote.
    valid_i = 1'b1; data_i = 32'hDEADBEEF;
    tick();
    valid_i = 1'b0;
    chk_all("accept");
    chk("accept/deadbeef", 64'(async_data_o), 64'h0000_0000_DEAD_BEEF);
    handshake(5, "single");

    // Back-to-back 1,2,3 with an echoing remote.
    sent_q.delete(); acc_cyc.delete();
    words[0] = 32'd1; words[1] = 32'd2; words[2] = 32'd3;
    widx = 0; ndeliv = 0;
    valid_i = 1'b1; data_i = words[0];
    for (int i = 0; i < 80 && !(ndeliv == 3 && ready_o); i++) begin
      nacc = acc_cyc.size();
      tick();
      if (async_req_o && !async_ack_i) begin
        chk("echo/order", 64'(async_data_o), 64'(words[ndeliv < 3 ? ndeliv : 2]));
        ndeliv++;
      end
      set_ack(async_req_o);
      if (acc_cyc.size() != nacc) begin
        widx++;
        if (widx < 3) data_i = words[widx];
        else valid_i = 1'b0;
      end
      chk_all("echo");
    end
    chk("echo/count", 64'(ndeliv), 64'd3);
    if (acc_cyc.size() == 3) begin
      chk("echo/gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'(2 * S + 3));
      chk("echo/gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'(2 * S + 3));
    end else chk("echo/accepts", 64'(acc_cyc.size()), 64'd3);
    valid_i = 1'b0;
    set_ack(1'b0);
    for (int i = 0; i < 2 * S + 4; i++) begin tick(); chk_all("echo_tail"); end

    // valid_i held, data_i changes mid-handshake.
    valid_i = 1'b1; data_i = 32'h1234_5678;
    tick();
    data_i = 32'h0000_00A5;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("hold");
      chk("hold/first", 64'(async_data_o), 64'h1234_5678);
    end
    handshake(0, "hold_hs");
    tick();
    valid_i = 1'b0;
    chk_all("a5");
    chk("a5/accept", 64'(async_data_o), 64'hA5);
    handshake(2, "a5_hs");

    // Reset asserted while in REQ_HI.
    valid_i = 1'b1; data_i = 32'h77;
    tick();
    valid_i = 1'b0;
    tick();
    rst_ni = 1'b0;
    #1;
    chk("midrst/req", 64'(async_req_o), 64'd0);
    chk("midrst/ready", 64'(ready_o), 64'd1);
    do_reset();
    valid_i = 1'b1; data_i = 32'h99;
    tick();
    valid_i = 1'b0;
    chk_all("postrst");
    chk("postrst/data", 64'(async_data_o), 64'h99);
    handshake(1, "postrst_hs");

    // Randomized traffic with a random-latency well-behaved remote.
    sent_q.delete(); acc_cyc.delete();
    rwait = -1; ndeliv = 0;
    for (int i = 0; i < 600; i++) begin
      valid_i = ($urandom_range(0, 2) != 0);
      data_i = $urandom;
      tick();
      if (async_req_o != async_ack_i) begin
        if (rwait < 0) rwait = $urandom_range(0, 4);
        if (rwait == 0) begin
          if (async_req_o) begin
            if (sent_q.size() > 0) chk("rnd/deliver", 64'(async_data_o), 64'(sent_q.pop_front()));
            else chk("rnd/unexpected_req", 64'(async_req_o), 64'd0);
            ndeliv++;
          end
          set_ack(async_req_o);
          rwait = -1;
        end else rwait--;
      end
      chk_all("rnd");
    end
    chk("rnd/progress", 64'(ndeliv > 20), 64'd1);
    valid_i = 1'b0;

`ifdef CDC_4PHASE_TX_TIMEOUT_EN
    // Ack withheld: sticky timeout exactly TO cycles after entering REQ_HI.
    do_reset();
    valid_i = 1'b1; data_i = 32'hC0FFEE;
    tick();
    a = cyc;
    valid_i = 1'b0;
    chk_all("to_acc");
    for (int i = 0; i < TO + 6; i++) begin
      tick();
      if (cyc - a >= TO) m_to = 1'b1;
      chk_all("to_wait");
    end
    handshake(0, "to_hs");
    chk("to/sticky", 64'(timeout_o), 64'd1);
    do_reset();
    chk("to/cleared", 64'(timeout_o), 64'd0);
`else
    a = 0;
    chk("to/tied_off", 64'(timeout_o), 64'(a));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
